// File: rtl/sabr_fxp_pkg.sv
// Shared fixed-point helpers for the SABR datapath blocks: product width,
// saturation bounds and rounding constants.
package sabr_fxp_pkg;

  localparam int unsigned FXP_MAX_W = 256;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic logic signed [FXP_MAX_W-1:0] fxp_one();
    logic signed [FXP_MAX_W-1:0] v;
    v = '0;
    v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic signed [FXP_MAX_W-1:0] sat_max(input int unsigned ow, input bit sgn);
    logic signed [FXP_MAX_W-1:0] one;
    one = fxp_one();
    return sgn ? (one <<< (ow - 1)) - one : (one << ow) - one;
  endfunction

  function automatic logic signed [FXP_MAX_W-1:0] sat_min(input int unsigned ow, input bit sgn);
    logic signed [FXP_MAX_W-1:0] one;
    one = fxp_one();
    return sgn ? -(one <<< (ow - 1)) : '0;
  endfunction

  // Half-LSB of the shifted result; zero when no fractional bits are dropped.
  function automatic logic signed [FXP_MAX_W-1:0] rnd_const(input int unsigned shift);
    logic signed [FXP_MAX_W-1:0] one;
    one = fxp_one();
    return (shift == 0) ? '0 : (one << (shift - 1));
  endfunction

endpackage

// File: rtl/sabr_fxp_round_sat.sv
// Combinational rescale of a signed full product: optional round-half-up,
// arithmetic right shift, then clamp or wrap with overflow detection.
module sabr_fxp_round_sat
  import sabr_fxp_pkg::*;
#(
  parameter int P          = 29,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1,
  parameter bit OUT_SIGNED = 1'b1
) (
  input  logic signed [P-1:0]         i_prod,
  output logic        [OUT_WIDTH-1:0] o_dout,
  output logic                        o_ovf
);

  localparam logic signed [P:0] RND =
    (ROUND != 0) ? (P+1)'(rnd_const(FRAC_SHIFT)) : '0;
  localparam logic signed [FXP_MAX_W-1:0] MAXV = sat_max(OUT_WIDTH, OUT_SIGNED);
  localparam logic signed [FXP_MAX_W-1:0] MINV = sat_min(OUT_WIDTH, OUT_SIGNED);

  // One guard bit so the rounding add can never wrap the product.
  logic signed [P:0]           w_sum;
  logic signed [P:0]           w_shift;
  logic signed [FXP_MAX_W-1:0] w_ext;
  logic                        w_hi;
  logic                        w_lo;

  assign w_sum   = {i_prod[P-1], i_prod} + RND;
  assign w_shift = w_sum >>> FRAC_SHIFT;
  assign w_ext   = {{(FXP_MAX_W-P-1){w_shift[P]}}, w_shift};
  assign w_hi    = (w_ext > MAXV);
  assign w_lo    = (w_ext < MINV);

  always_comb begin
    o_dout = w_ext[OUT_WIDTH-1:0];
    o_ovf  = w_hi | w_lo;
    if (SATURATE != 0) begin
      if (w_hi)      o_dout = MAXV[OUT_WIDTH-1:0];
      else if (w_lo) o_dout = MINV[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sabr_fxp_mul_pipe.sv
// ce-stallable fixed-point multiplier pipeline with valid sideband and
// per-sample / sticky overflow flags.
module sabr_fxp_mul_pipe
  import sabr_fxp_pkg::*;
#(
  parameter int A_WIDTH    = 12,
  parameter int B_WIDTH    = 80,
  parameter int A_SIGNED   = 1,
  parameter int B_SIGNED   = 0,
  parameter int OUT_WIDTH  = 90,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0,
  parameter int NUM_STAGE  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 ovf_clr,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 out_valid,
  output logic                 ovf,
  output logic                 ovf_sticky
);

  localparam int          P          = prod_width(A_WIDTH, B_WIDTH);
  localparam int unsigned ND         = NUM_STAGE - 2;
  localparam bit          OUT_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic [A_WIDTH-1:0]   r_a;
  logic [B_WIDTH-1:0]   r_b;
  logic                 r_v1;
  logic signed [P-1:0]  r_pipe [ND];
  logic [ND-1:0]        r_vp;
  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_vout;
  logic                 r_ovf;
  logic                 r_ovs;

  logic signed [P-1:0]  w_a_p;
  logic signed [P-1:0]  w_b_p;
  logic signed [P-1:0]  w_prod;
  logic [OUT_WIDTH-1:0] w_dout;
  logic                 w_ovf;
  logic                 w_ovf_v;

  // Both operands are widened to P bits so the truncated multiply stays exact.
  assign w_a_p  = {{(B_WIDTH+1){(A_SIGNED != 0) ? r_a[A_WIDTH-1] : 1'b0}}, r_a};
  assign w_b_p  = {{(A_WIDTH+1){(B_SIGNED != 0) ? r_b[B_WIDTH-1] : 1'b0}}, r_b};
  assign w_prod = w_a_p * w_b_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
      r_vp <= '0;
      for (int unsigned i = 0; i < ND; i++) r_pipe[i] <= '0;
    end else if (ce) begin
      r_a       <= din0;
      r_b       <= din1;
      r_v1      <= in_valid;
      r_pipe[0] <= w_prod;
      r_vp[0]   <= r_v1;
      for (int unsigned i = 1; i < ND; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        r_vp[i]   <= r_vp[i-1];
      end
    end
  end

  sabr_fxp_round_sat #(
    .P          (P),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .ROUND      (ROUND),
    .SATURATE   (SATURATE),
    .OUT_SIGNED (OUT_SIGNED)
  ) u_round_sat (
    .i_prod (r_pipe[ND-1]),
    .o_dout (w_dout),
    .o_ovf  (w_ovf)
  );

  assign w_ovf_v = w_ovf & r_vp[ND-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
      r_vout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (ce) begin
      r_dout <= w_dout;
      r_vout <= r_vp[ND-1];
      r_ovf  <= w_ovf_v;
    end
  end

  // Clear acts regardless of ce; a same-edge set takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ovs <= 1'b0;
    else if (ce && w_ovf_v)   r_ovs <= 1'b1;
    else if (ovf_clr)         r_ovs <= 1'b0;
  end

  assign dout       = r_dout;
  assign out_valid  = r_vout;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_ovs;

endmodule

// File: tb/tb_sabr_fxp_mul_pipe.sv
// Bench for sabr_fxp_mul_pipe: a saturating 4-stage and a wrapping 3-stage
// instance share stimulus; a queue-based arithmetic model checks every cycle.
module tb_sabr_fxp_mul_pipe;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [11:0] din0 = '0;
  logic [15:0]        din1 = '0;
  logic               ovf_clr = 1'b0;

  logic [15:0] m_dout, w_dout;
  logic        m_vld, w_vld, m_ovf, w_ovf, m_st, w_st;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sabr_fxp_mul_pipe #(
    .A_WIDTH(12), .B_WIDTH(16), .A_SIGNED(1), .B_SIGNED(0), .OUT_WIDTH(16),
    .FRAC_SHIFT(8), .ROUND(1), .SATURATE(1), .NUM_STAGE(4)
  ) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .ovf_clr(ovf_clr), .dout(m_dout), .out_valid(m_vld),
    .ovf(m_ovf), .ovf_sticky(m_st)
  );

  sabr_fxp_mul_pipe #(
    .A_WIDTH(12), .B_WIDTH(16), .A_SIGNED(1), .B_SIGNED(0), .OUT_WIDTH(16),
    .FRAC_SHIFT(8), .ROUND(1), .SATURATE(0), .NUM_STAGE(3)
  ) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .ovf_clr(ovf_clr), .dout(w_dout), .out_valid(w_vld),
    .ovf(w_ovf), .ovf_sticky(w_st)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference arithmetic: exact product, +0.5 LSB, floor divide by 256, range check.
  task automatic ref_mul(input logic signed [11:0] a, input logic [15:0] b, input bit sat,
                         output logic [15:0] d, output bit ov);
    longint p, v;
    p  = longint'(a) * longint'(b);
    v  = (p + 128) >>> 8;
    ov = (v > 32767) || (v < -32768);
    d  = 16'(v);
    if (sat && v > 32767)  d = 16'h7FFF;
    if (sat && v < -32768) d = 16'h8000;
  endtask

  typedef struct { bit v; logic signed [11:0] a; logic [15:0] b; } samp_t;
  samp_t q[$];
  bit    ms_exp = 1'b0;
  bit    ws_exp = 1'b0;

  // Model: each accepted ce edge shifts one sample in; output after edge k is
  // the sample accepted NUM_STAGE-1 edges earlier.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      ms_exp = 1'b0;
      ws_exp = 1'b0;
    end else begin
      logic [15:0] d;
      bit ov, set_m, set_w;
      int n;
      if (ce) q.push_back('{in_valid, din0, din1});
      n = q.size();
      set_m = 1'b0;
      set_w = 1'b0;
      if (ce && n >= 4) begin ref_mul(q[n-4].a, q[n-4].b, 1'b1, d, ov); set_m = ov && q[n-4].v; end
      if (ce && n >= 3) begin ref_mul(q[n-3].a, q[n-3].b, 1'b0, d, ov); set_w = ov && q[n-3].v; end
      if (set_m) ms_exp = 1'b1; else if (ovf_clr) ms_exp = 1'b0;
      if (set_w) ws_exp = 1'b1; else if (ovf_clr) ws_exp = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic [15:0] d;
      bit ov, v;
      int n;
      n = q.size();
      d = '0; ov = 1'b0; v = 1'b0;
      if (n >= 4) begin ref_mul(q[n-4].a, q[n-4].b, 1'b1, d, ov); v = q[n-4].v; end
      chk("sat_dout", 32'(m_dout), 32'(d));
      chk("sat_valid", 32'(m_vld), 32'(v));
      chk("sat_ovf", 32'(m_ovf), 32'(ov && v));
      chk("sat_sticky", 32'(m_st), 32'(ms_exp));
      d = '0; ov = 1'b0; v = 1'b0;
      if (n >= 3) begin ref_mul(q[n-3].a, q[n-3].b, 1'b0, d, ov); v = q[n-3].v; end
      chk("wrap_dout", 32'(w_dout), 32'(d));
      chk("wrap_valid", 32'(w_vld), 32'(v));
      chk("wrap_ovf", 32'(w_ovf), 32'(ov && v));
      chk("wrap_sticky", 32'(w_st), 32'(ws_exp));
    end
  end

  typedef struct {
    logic signed [11:0] a;
    logic [15:0]        b;
    logic [15:0]        d;
    bit                 ov;
    logic [15:0]        wd;
  } vec_t;
  vec_t tbl[11];

  // One isolated sample: wrap result after 3 edges, saturated result after 4.
  task automatic run_vec(input vec_t t);
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; din0 = t.a; din1 = t.b;
    @(negedge clk);
    in_valid = 1'b0; din0 = 12'($urandom); din1 = 16'($urandom);
    @(negedge clk);
    @(negedge clk);
    chk("vec_wrap_dout", 32'(w_dout), 32'(t.wd));
    chk("vec_wrap_ovf", 32'(w_ovf), 32'(t.ov));
    chk("vec_wrap_valid_lat3", 32'(w_vld), 32'd1);
    chk("vec_sat_valid_early", 32'(m_vld), 32'd0);
    @(negedge clk);
    chk("vec_sat_dout", 32'(m_dout), 32'(t.d));
    chk("vec_sat_ovf", 32'(m_ovf), 32'(t.ov));
    chk("vec_sat_valid_lat4", 32'(m_vld), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{-12'sd3,    16'h0180, 16'hFFFC, 1'b0, 16'hFFFC};
    tbl[1]  = '{12'sd2047,  16'hFFFF, 16'h7FFF, 1'b1, 16'hFEF8};
    tbl[2]  = '{-12'sd2048, 16'hFFFF, 16'h8000, 1'b1, 16'h0008};
    tbl[3]  = '{12'sd1,     16'h0080, 16'h0001, 1'b0, 16'h0001};
    tbl[4]  = '{12'sd1,     16'h007F, 16'h0000, 1'b0, 16'h0000};
    tbl[5]  = '{-12'sd1,    16'h0081, 16'hFFFF, 1'b0, 16'hFFFF};
    tbl[6]  = '{12'sd2047,  16'h1001, 16'h7FF8, 1'b0, 16'h7FF8};
    tbl[7]  = '{12'sd2047,  16'h1002, 16'h7FFF, 1'b1, 16'h8000};
    tbl[8]  = '{-12'sd2048, 16'h1000, 16'h8000, 1'b0, 16'h8000};
    tbl[9]  = '{-12'sd2048, 16'h1001, 16'h8000, 1'b1, 16'h7FF8};
    tbl[10] = '{12'sd0,     16'hFFFF, 16'h0000, 1'b0, 16'h0000};

    #1 reset = 1'b1;
    #2;
    chk("rst_sat_dout", 32'(m_dout), 32'd0);
    chk("rst_sat_valid", 32'(m_vld), 32'd0);
    chk("rst_sat_ovf", 32'(m_ovf), 32'd0);
    chk("rst_sat_sticky", 32'(m_st), 32'd0);
    chk("rst_wrap_dout", 32'(w_dout), 32'd0);
    chk("rst_wrap_valid", 32'(w_vld), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Sticky: clear, then clear on the same edge as a valid overflow, then clear while stalled.
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("sticky_cleared", 32'(m_st), 32'd0);
    ce = 1'b1; in_valid = 1'b1; din0 = 12'sd2047; din1 = 16'hFFFF;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk);
    chk("sticky_set_wins", 32'(m_st), 32'd1);
    chk("sticky_ovf_now", 32'(m_ovf), 32'd1);
    ce = 1'b0;
    @(negedge clk);
    chk("sticky_clr_stalled", 32'(m_st), 32'd0);
    chk("ovf_held_stalled", 32'(m_ovf), 32'd1);
    ovf_clr = 1'b0; ce = 1'b1;

    // Stalls and bubbles: valid 1,1,0,1 with two ce-low cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din0 = 12'($urandom); din1 = 16'($urandom);
      case (i)
        0, 1, 5: begin ce = 1'b1; in_valid = 1'b1; end
        2, 3:    begin ce = 1'b0; in_valid = 1'b1; end
        4:       begin ce = 1'b1; in_valid = 1'b0; end
        default: begin ce = 1'b1; in_valid = 1'b0; end
      endcase
    end
    repeat (6) @(negedge clk);

    // Async reset between edges with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b1; din0 = 12'sd2047; din1 = 16'hFFFF;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_sat_dout", 32'(m_dout), 32'd0);
    chk("arst_sat_valid", 32'(m_vld), 32'd0);
    chk("arst_sat_ovf", 32'(m_ovf), 32'd0);
    chk("arst_sat_sticky", 32'(m_st), 32'd0);
    chk("arst_wrap_dout", 32'(w_dout), 32'd0);
    chk("arst_wrap_valid", 32'(w_vld), 32'd0);
    chk("arst_wrap_ovf", 32'(w_ovf), 32'd0);
    chk("arst_wrap_sticky", 32'(w_st), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(tbl[0]);

    // Randomized traffic with stalls, bubbles and occasional clears.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      ce       = ($urandom_range(0, 99) < 85);
      in_valid = ($urandom_range(0, 99) < 70);
      ovf_clr  = ($urandom_range(0, 99) < 5);
      din0     = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 12'sd2047 : -12'sd2048)
                                               : 12'($urandom);
      din1     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    end
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
